// File: rtl/prco_lmem_arb.sv
// rtl/prco_lmem_arb.sv - fetch/load-store arbiter for the shared single-port local memory
module prco_lmem_arb #(
    parameter int P_STARVE_MAX = 3,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_p_cp,
    input  logic                   i_f_req,
    input  logic [15:0]            i_f_addr,
    output logic                   q_f_ack,
    output logic [15:0]            q_f_rdata,
    input  logic                   i_d_req,
    input  logic                   i_d_we,
    input  logic [15:0]            i_d_addr,
    input  logic [15:0]            i_d_wdata,
    output logic                   q_d_ack,
    output logic [15:0]            q_d_rdata,
    output logic                   q_mem_we,
    output logic [15:0]            q_mem_addr,
    output logic [15:0]            q_mem_dina,
    input  logic [15:0]            i_mem_douta,
    output logic                   q_f_stalled,
    output logic [P_CNT_WIDTH-1:0] q_conflicts
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(P_STARVE_MAX);
    localparam logic [P_CNT_WIDTH-1:0] C_CNT_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic        f_req_eff;
    logic        f_grant;
    logic        d_grant;
    logic [3:0]  starve_cnt;
    logic        forced;
    logic        f_ack_r;
    logic        d_ack_r;
    logic [15:0] f_data_new;
    logic [15:0] f_rdata_hold;

    // Grant decision and memory drive; a flush removes fetch from contention this cycle
    always_comb begin
        f_req_eff   = i_f_req && !i_p_cp;
        f_grant     = f_req_eff && (!i_d_req || forced);
        d_grant     = i_d_req && !f_grant;
        q_mem_addr  = 16'h0000;
        q_mem_we    = 1'b0;
        q_mem_dina  = i_d_wdata;
        if (f_grant) begin
            q_mem_addr = i_f_addr;
        end else if (d_grant) begin
            q_mem_addr = i_d_addr;
            q_mem_we   = i_d_we && !i_reset;
        end
        q_f_stalled = i_f_req && !f_grant;
    end

    // Acks are registered; a flush in the ack cycle hides the fetch ack and keeps old fetch data
    always_comb begin
        q_f_ack   = f_ack_r && !i_p_cp && !i_reset;
        q_d_ack   = d_ack_r && !i_reset;
        q_f_rdata = q_f_ack ? f_data_new : f_rdata_hold;
    end

    // Completion capture, starvation guard and conflict counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            f_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            f_data_new   <= 16'h0000;
            f_rdata_hold <= 16'h0000;
            q_d_rdata    <= 16'h0000;
            starve_cnt   <= 4'd0;
            forced       <= 1'b0;
            q_conflicts  <= '0;
        end else begin
            f_ack_r      <= f_grant;
            d_ack_r      <= d_grant;
            f_rdata_hold <= q_f_rdata;
            if (f_grant) begin
                f_data_new <= i_mem_douta;
            end
            if (d_grant && !i_d_we) begin
                q_d_rdata <= i_mem_douta;
            end
            if (f_req_eff && !f_grant) begin
                starve_cnt <= starve_cnt + 4'd1;
                forced     <= (starve_cnt + 4'd1) == C_STARVE_LIMIT;
            end else begin
                starve_cnt <= 4'd0;
                forced     <= 1'b0;
            end
            if (i_f_req && i_d_req && (q_conflicts != '1)) begin
                q_conflicts <= q_conflicts + C_CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_prco_lmem_arb.sv
// tb/tb_prco_lmem_arb.sv - directed scoreboard bench for prco_lmem_arb
module tb_prco_lmem_arb;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_p_cp = 1'b0;
    logic        i_f_req = 1'b0;
    logic [15:0] i_f_addr = 16'h0;
    logic        i_d_req = 1'b0;
    logic        i_d_we = 1'b0;
    logic [15:0] i_d_addr = 16'h0;
    logic [15:0] i_d_wdata = 16'h0;

    logic        q_f_ack, q_d_ack, q_mem_we, q_f_stalled;
    logic [15:0] q_f_rdata, q_d_rdata, q_mem_addr, q_mem_dina, i_mem_douta;
    logic [15:0] q_conflicts;

    logic        s_f_ack, s_d_ack, s_mem_we, s_f_stalled;
    logic [15:0] s_f_rdata, s_d_rdata, s_mem_addr, s_mem_dina, s_mem_douta;
    logic [3:0]  s_conflicts;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    always #5 i_clk = ~i_clk;

    prco_lmem_arb #(.P_STARVE_MAX(3), .P_CNT_WIDTH(16)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp),
        .i_f_req(i_f_req), .i_f_addr(i_f_addr), .q_f_ack(q_f_ack), .q_f_rdata(q_f_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .q_d_ack(q_d_ack), .q_d_rdata(q_d_rdata),
        .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr), .q_mem_dina(q_mem_dina),
        .i_mem_douta(i_mem_douta), .q_f_stalled(q_f_stalled), .q_conflicts(q_conflicts)
    );

    prco_lmem_arb #(.P_STARVE_MAX(3), .P_CNT_WIDTH(4)) u_sat (
        .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp),
        .i_f_req(i_f_req), .i_f_addr(i_f_addr), .q_f_ack(s_f_ack), .q_f_rdata(s_f_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .q_d_ack(s_d_ack), .q_d_rdata(s_d_rdata),
        .q_mem_we(s_mem_we), .q_mem_addr(s_mem_addr), .q_mem_dina(s_mem_dina),
        .i_mem_douta(s_mem_douta), .q_f_stalled(s_f_stalled), .q_conflicts(s_conflicts)
    );

    assign i_mem_douta = mem[q_mem_addr];
    assign s_mem_douta = mem[s_mem_addr];

    always @(posedge i_clk) begin
        if (q_mem_we) mem[q_mem_addr] <= q_mem_dina;
    end

    typedef struct {
        logic        f_ack;
        logic [15:0] f_data;
        logic        d_ack;
        logic        d_upd;
        logic [15:0] d_data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_conf = 0;
    logic [15:0] m_f_rdata = 16'h0;
    logic [15:0] m_d_rdata = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // eg: expected grant this cycle, 0 none, 1 fetch, 2 data
    task automatic step(input logic rst, input logic pcp, input logic fr, input logic [15:0] fa,
                        input logic dr, input logic dwe, input logic [15:0] da, input logic [15:0] dwd,
                        input int eg);
        exp_t        e;
        exp_t        n;
        logic        exp_f;
        logic [15:0] exp_addr;
        int          sat;
        i_reset = rst; i_p_cp = pcp;
        i_f_req = fr; i_f_addr = fa;
        i_d_req = dr; i_d_we = dwe; i_d_addr = da; i_d_wdata = dwd;
        @(negedge i_clk);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{f_ack: 1'b0, f_data: 16'h0, d_ack: 1'b0, d_upd: 1'b0, d_data: 16'h0};
        exp_addr = (eg == 1) ? fa : (eg == 2) ? da : 16'h0;
        chk("mem_we", q_mem_we, (eg == 2) && dwe && !rst);
        chk("mem_addr", q_mem_addr, exp_addr);
        chk("mem_dina", q_mem_dina, dwd);
        chk("f_stalled", q_f_stalled, fr && (eg != 1));
        chk("sat_mem_we", s_mem_we, (eg == 2) && dwe && !rst);
        if (!rst) begin
            exp_f = e.f_ack && !pcp;
            if (exp_f) m_f_rdata = e.f_data;
            if (e.d_ack && e.d_upd) m_d_rdata = e.d_data;
            sat = (exp_conf > 15) ? 15 : exp_conf;
            chk("f_ack", q_f_ack, exp_f);
            chk("d_ack", q_d_ack, e.d_ack);
            chk("f_rdata", q_f_rdata, m_f_rdata);
            chk("d_rdata", q_d_rdata, m_d_rdata);
            chk("conflicts", q_conflicts, exp_conf);
            chk("sat_f_ack", s_f_ack, exp_f);
            chk("sat_d_ack", s_d_ack, e.d_ack);
            chk("sat_f_rdata", s_f_rdata, m_f_rdata);
            chk("sat_d_rdata", s_d_rdata, m_d_rdata);
            chk("sat_conflicts", s_conflicts, sat);
            chk("sat_stalled", s_f_stalled, fr && (eg != 1));
            chk("sat_mem_addr", s_mem_addr, exp_addr);
            chk("sat_mem_dina", s_mem_dina, dwd);
            n.f_ack  = (eg == 1);
            n.f_data = ref_mem[fa];
            n.d_ack  = (eg == 2);
            n.d_upd  = !dwe;
            n.d_data = ref_mem[da];
            sb.push_back(n);
            if ((eg == 2) && dwe) ref_mem[da] = dwd;
            if (fr && dr && exp_conf < 65535) exp_conf++;
        end else begin
            sb.delete();
            m_f_rdata = 16'h0;
            m_d_rdata = 16'h0;
            exp_conf  = 0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5a5a;
            ref_mem[i] = 16'(i) ^ 16'h5a5a;
        end
        mem[0] = 16'h20ab; ref_mem[0] = 16'h20ab;
        mem[1] = 16'h21cd; ref_mem[1] = 16'h21cd;

        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        idle();

        // fetch-only reads
        step(0, 0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
        step(0, 0, 1, 16'h0001, 0, 0, 16'h0, 16'h0, 1);
        idle();
        idle();

        // data write then read back
        step(0, 0, 0, 16'h0, 1, 1, 16'h0010, 16'h1234, 2);
        step(0, 0, 0, 16'h0, 1, 0, 16'h0010, 16'h0, 2);
        idle();

        // both held: data, data, data, fetch, repeat
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 16'h0002, 1, 0, 16'h0003, 16'h0, (i % 4 == 3) ? 1 : 2);
        idle();

        // flush cancels a granted fetch's ack and suppresses the flushed request
        step(0, 0, 1, 16'h0004, 0, 0, 16'h0, 16'h0, 1);
        step(0, 1, 1, 16'h0004, 0, 0, 16'h0, 16'h0, 0);
        idle();

        // flush with both pending clears the starvation count
        step(0, 0, 1, 16'h0005, 1, 0, 16'h0006, 16'h0, 2);
        step(0, 0, 1, 16'h0005, 1, 0, 16'h0006, 16'h0, 2);
        step(0, 1, 1, 16'h0005, 1, 0, 16'h0006, 16'h0, 2);
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 16'h0005, 1, 0, 16'h0006, 16'h0, (i == 3) ? 1 : 2);
        idle();

        // reset during a data-write grant: no write, everything cleared
        step(0, 0, 1, 16'h0007, 1, 0, 16'h0008, 16'h0, 2);
        step(1, 0, 0, 16'h0, 1, 1, 16'h0020, 16'hbeef, 2);
        idle();
        step(0, 0, 0, 16'h0, 1, 0, 16'h0020, 16'h0, 2);
        idle();

        // saturation of the narrow conflict counter
        for (int i = 0; i < 20; i++)
            step(0, 0, 1, 16'h0009, 1, 0, 16'h000a, 16'h0, (i % 4 == 3) ? 1 : 2);
        idle();
        chk("sat_final", s_conflicts, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
